// File: rtl/gclk_divgate.sv
// rtl/gclk_divgate.sv - glitch-free programmable divided clock for a global clock buffer
// Phases always run to completion; only CLR may cut a phase short.
module gclk_divgate #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             EN,
  input  logic [WIDTH-1:0] DIV,
  input  logic             LOAD,
  output logic             Z,
  output logic             RDY,
  output logic             TICK
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] h_q, h_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic             z_q, z_d;
  logic             rdy_q, rdy_d;
  logic             tick_q, tick_d;
  logic [WIDTH-1:0] reload;
  logic             phase_end;

  // A LOAD on a period-start edge must take effect in that very period.
  assign reload    = LOAD ? DIV : shadow_q;
  assign phase_end = (cnt_q == h_q);

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      h_q      <= '0;
      shadow_q <= '0;
      z_q      <= 1'b0;
      rdy_q    <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      h_q      <= h_d;
      shadow_q <= shadow_d;
      z_q      <= z_d;
      rdy_q    <= rdy_d;
      tick_q   <= tick_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    h_d      = h_q;
    shadow_d = LOAD ? DIV : shadow_q;
    z_d      = z_q;
    rdy_d    = rdy_q;
    tick_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        z_d   = 1'b0;
        rdy_d = 1'b0;
        if (EN) begin
          state_d = ST_RUN;
          z_d     = 1'b1;
          tick_d  = 1'b1;
          rdy_d   = 1'b1;
          cnt_d   = '0;
          h_d     = reload;
        end
      end
      ST_RUN, ST_DRAIN: begin
        state_d = EN ? ST_RUN : ST_DRAIN;
        if (!phase_end) begin
          cnt_d = cnt_q + WIDTH'(1);
        end else begin
          cnt_d = '0;
          if (z_q) begin
            z_d = 1'b0;
          end else if (EN) begin
            // Low phase ends with a live run request: start the next period.
            state_d = ST_RUN;
            z_d     = 1'b1;
            tick_d  = 1'b1;
            h_d     = reload;
          end else begin
            state_d = ST_IDLE;
            rdy_d   = 1'b0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        z_d     = 1'b0;
        rdy_d   = 1'b0;
      end
    endcase
  end

  assign Z    = z_q;
  assign RDY  = rdy_q;
  assign TICK = tick_q;

endmodule
